bp_counter_table: RTL and testbench

//  Parametrised branch direction predictor: a table of 2^IDX_W saturating CTR_W-bit counters.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bp_counter_table_if.sv | 46 ++++
 rtl/bp_sat_update.sv | 15 +
 rtl/bp_counter_table.sv | 108 ++++++++++
 tb/tb_bp_counter_table.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch direction predictor tables.
// Holds the indexing modes and the saturating counter step.
package bp_pkg;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;
    localparam int CTR_MAX_W    = 4;

    // Counters travel zero-extended to CTR_MAX_W bits; width picks the ceiling.
    function automatic logic [CTR_MAX_W-1:0] sat_next(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 taken,
        input int unsigned          width
    );
        logic [CTR_MAX_W:0]   top;
        logic [CTR_MAX_W-1:0] max;
        logic [CTR_MAX_W-1:0] res;
        top = (CTR_MAX_W+1)'(1) << width;
        max = CTR_MAX_W'(top - 1'b1);
        res = ctr;
        if (taken) begin
            if (ctr != max) res = ctr + 1'b1;
        end else begin
            if (ctr != '0) res = ctr - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_counter_table_if.sv
// Fetch/resolve side bundle of the branch direction predictor.
// master = pipeline side, slave = predictor.
interface bp_counter_table_if #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6,
    parameter int GHR_W = 6
);

    logic             en;
    logic             lookup_valid;
    logic [PC_W-1:0]  lookup_pc;
    logic             predict_valid;
    logic             predict;
    logic [IDX_W-1:0] predict_idx;
    logic             update_valid;
    logic [IDX_W-1:0] update_idx;
    logic             update_result;
    logic [GHR_W-1:0] ghr_out;

    modport master (
        output en,
        output lookup_valid,
        output lookup_pc,
        output update_valid,
        output update_idx,
        output update_result,
        input  predict_valid,
        input  predict,
        input  predict_idx,
        input  ghr_out
    );

    modport slave (
        input  en,
        input  lookup_valid,
        input  lookup_pc,
        input  update_valid,
        input  update_idx,
        input  update_result,
        output predict_valid,
        output predict,
        output predict_idx,
        output ghr_out
    );

endinterface

// File: rtl/bp_sat_update.sv
// Combinational next-state for one saturating direction counter.
// Shared with chooser tables that train the same kind of counter.
module bp_sat_update
    import bp_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             taken_i,
    output logic [CTR_W-1:0] ctr_o
);

    assign ctr_o = CTR_W'(sat_next(CTR_MAX_W'(ctr_i), taken_i, CTR_W));

endmodule

// File: rtl/bp_counter_table.sv
// Bimodal / gshare table of saturating counters with a registered lookup.
// Lookups read pre-update state; updates land at the same clock edge.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6,
    parameter int CTR_W = 2,
    parameter int GHR_W = 6,
    parameter int MODE  = MODE_BIMODAL
) (
    input  logic              clk,
    input  logic              rst,
    bp_counter_table_if.slave bus
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] RST_CTR = CTR_W'(1 << (CTR_W-1));

    logic [CTR_W-1:0] ctr_q [DEPTH];
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    logic             pv_q;
    logic             pv_d;
    logic             p_q;
    logic             p_d;
    logic [IDX_W-1:0] pidx_q;
    logic [IDX_W-1:0] pidx_d;

    logic             lk_en;
    logic             upd_en;
    logic [IDX_W-1:0] lk_idx;
    logic [CTR_W-1:0] upd_old;
    logic [CTR_W-1:0] upd_new;
    logic             unused_pc;

    assign lk_en  = bus.en & bus.lookup_valid;
    assign upd_en = bus.en & bus.update_valid;

    assign unused_pc = ^{bus.lookup_pc[1:0],
                         bus.lookup_pc[PC_W-1:IDX_W+2]};

    // History is zero-extended into the index, never the other way round.
    always_comb begin
        lk_idx = bus.lookup_pc[IDX_W+1:2];
        if (MODE == MODE_GSHARE) begin
            lk_idx = bus.lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
        end
    end

    assign upd_old = ctr_q[bus.update_idx];

    bp_sat_update #(
        .CTR_W (CTR_W)
    ) u_sat (
        .ctr_i   (upd_old),
        .taken_i (bus.update_result),
        .ctr_o   (upd_new)
    );

    // Truncating the concatenation drops the oldest outcome.
    always_comb begin
        ghr_d = ghr_q;
        if (MODE == MODE_GSHARE && upd_en) begin
            ghr_d = GHR_W'({ghr_q, bus.update_result});
        end
    end

    always_comb begin
        pv_d   = lk_en;
        p_d    = p_q;
        pidx_d = pidx_q;
        if (lk_en) begin
            p_d    = ctr_q[lk_idx][CTR_W-1];
            pidx_d = lk_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q  <= '0;
            pv_q   <= 1'b0;
            p_q    <= 1'b1;
            pidx_q <= '0;
        end else begin
            ghr_q  <= ghr_d;
            pv_q   <= pv_d;
            p_q    <= p_d;
            pidx_q <= pidx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= RST_CTR;
            end
        end else if (upd_en) begin
            ctr_q[bus.update_idx] <= upd_new;
        end
    end

    assign bus.predict_valid = pv_q;
    assign bus.predict       = p_q;
    assign bus.predict_idx   = pidx_q;
    assign bus.ghr_out       = ghr_q;

endmodule

// File: tb/tb_bp_counter_table.sv
// Directed bench: bimodal 2-bit, gshare GHR_W=4 and 1-bit counter variants.
// Vector table for the bimodal table plus hand sequences for reset and history.
module tb_bp_counter_table;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    bp_counter_table_if #(.PC_W(32), .IDX_W(6), .GHR_W(6)) if0 ();
    bp_counter_table_if #(.PC_W(32), .IDX_W(6), .GHR_W(4)) if1 ();
    bp_counter_table_if #(.PC_W(32), .IDX_W(6), .GHR_W(6)) if2 ();

    bp_counter_table #(
        .PC_W(32), .IDX_W(6), .CTR_W(2), .GHR_W(6), .MODE(0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    bp_counter_table #(
        .PC_W(32), .IDX_W(6), .CTR_W(2), .GHR_W(4), .MODE(1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    bp_counter_table #(
        .PC_W(32), .IDX_W(6), .CTR_W(1), .GHR_W(6), .MODE(0)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    typedef struct {
        logic        en;
        logic        lv;
        logic [31:0] pc;
        logic        uv;
        logic [5:0]  ui;
        logic        ur;
        logic        pv;
        logic        p;
        logic [5:0]  pi;
    } vec_t;

    vec_t vt [17];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        if0.en = 1'b1; if0.lookup_valid = 1'b0; if0.lookup_pc = '0;
        if0.update_valid = 1'b0; if0.update_idx = '0; if0.update_result = 1'b0;
        if1.en = 1'b1; if1.lookup_valid = 1'b0; if1.lookup_pc = '0;
        if1.update_valid = 1'b0; if1.update_idx = '0; if1.update_result = 1'b0;
        if2.en = 1'b1; if2.lookup_valid = 1'b0; if2.lookup_pc = '0;
        if2.update_valid = 1'b0; if2.update_idx = '0; if2.update_result = 1'b0;
    endtask

    task automatic upd1(input logic r);
        if1.update_valid = 1'b1; if1.update_idx = 6'd0; if1.update_result = r;
        tick();
        if1.update_valid = 1'b0;
    endtask

    task automatic upd2(input logic r);
        if2.update_valid = 1'b1; if2.update_idx = 6'd3; if2.update_result = r;
        tick();
        if2.update_valid = 1'b0;
    endtask

    task automatic look2(input string name, input logic exp);
        if2.lookup_valid = 1'b1; if2.lookup_pc = 32'h0C;
        tick();
        if2.lookup_valid = 1'b0;
        chk(name, {31'd0, if2.predict}, {31'd0, exp});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        //        en lv  pc            uv ui     ur  pv p  pi
        vt[0]  = '{1, 1, 32'h40,       0, 6'h00, 0,  1, 1, 6'h10};
        vt[1]  = '{1, 0, 32'h00,       1, 6'h10, 0,  0, 1, 6'h10};
        vt[2]  = '{1, 0, 32'h00,       1, 6'h10, 0,  0, 1, 6'h10};
        vt[3]  = '{1, 1, 32'h40,       1, 6'h10, 0,  1, 0, 6'h10};
        vt[4]  = '{1, 1, 32'h40,       1, 6'h10, 1,  1, 0, 6'h10};
        vt[5]  = '{1, 1, 32'h40,       1, 6'h10, 1,  1, 0, 6'h10};
        vt[6]  = '{1, 1, 32'h40,       1, 6'h10, 1,  1, 1, 6'h10};
        vt[7]  = '{1, 1, 32'h40,       1, 6'h10, 1,  1, 1, 6'h10};
        vt[8]  = '{1, 1, 32'h40,       1, 6'h10, 0,  1, 1, 6'h10};
        vt[9]  = '{1, 1, 32'h40,       1, 6'h10, 0,  1, 1, 6'h10};
        vt[10] = '{1, 1, 32'h40,       0, 6'h00, 0,  1, 0, 6'h10};
        vt[11] = '{1, 1, 32'h14,       1, 6'h05, 0,  1, 1, 6'h05};
        vt[12] = '{1, 1, 32'h14,       0, 6'h00, 0,  1, 0, 6'h05};
        vt[13] = '{1, 1, 32'hFFFFFF43, 0, 6'h00, 0,  1, 0, 6'h10};
        vt[14] = '{0, 1, 32'h14,       1, 6'h05, 1,  0, 0, 6'h10};
        vt[15] = '{1, 1, 32'h14,       0, 6'h00, 0,  1, 0, 6'h05};
        vt[16] = '{1, 1, 32'hFC,       0, 6'h00, 0,  1, 1, 6'h3F};

        idle_all();
        rst = 1'b1;
        #12;
        chk("rst_pv",  {31'd0, if0.predict_valid}, 32'd0);
        chk("rst_p",   {31'd0, if0.predict}, 32'd1);
        chk("rst_idx", {26'd0, if0.predict_idx}, 32'd0);
        chk("rst_ghr", {28'd0, if1.ghr_out}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 17; i++) begin
            if0.en            = vt[i].en;
            if0.lookup_valid  = vt[i].lv;
            if0.lookup_pc     = vt[i].pc;
            if0.update_valid  = vt[i].uv;
            if0.update_idx    = vt[i].ui;
            if0.update_result = vt[i].ur;
            tick();
            chk($sformatf("v%0d_pv", i), {31'd0, if0.predict_valid},
                {31'd0, vt[i].pv});
            chk($sformatf("v%0d_p", i), {31'd0, if0.predict},
                {31'd0, vt[i].p});
            chk($sformatf("v%0d_idx", i), {26'd0, if0.predict_idx},
                {26'd0, vt[i].pi});
        end
        idle_all();
        chk("bimodal_ghr", {26'd0, if0.ghr_out}, 32'd0);

        // async reset with predict_valid high, no clock edge in between
        if0.lookup_valid = 1'b1; if0.lookup_pc = 32'h14;
        tick();
        chk("pre_rst_pv", {31'd0, if0.predict_valid}, 32'd1);
        chk("pre_rst_p", {31'd0, if0.predict}, 32'd0);
        idle_all();
        #2 rst = 1'b1;
        #1;
        chk("arst_pv",  {31'd0, if0.predict_valid}, 32'd0);
        chk("arst_p",   {31'd0, if0.predict}, 32'd1);
        chk("arst_idx", {26'd0, if0.predict_idx}, 32'd0);
        #2 rst = 1'b0;
        if0.lookup_valid = 1'b1; if0.lookup_pc = 32'h40;
        tick();
        chk("post_rst_p10", {31'd0, if0.predict}, 32'd1);
        if0.lookup_pc = 32'h14;
        tick();
        chk("post_rst_p05", {31'd0, if0.predict}, 32'd1);
        if0.lookup_valid = 1'b0;
        if0.update_valid = 1'b1; if0.update_idx = 6'h10; if0.update_result = 1'b0;
        tick();
        if0.update_valid = 1'b0;
        if0.lookup_valid = 1'b1; if0.lookup_pc = 32'h40;
        tick();
        chk("post_rst_weak", {31'd0, if0.predict}, 32'd0);
        idle_all();

        // gshare history
        upd1(1'b1);
        chk("ghr_1", {28'd0, if1.ghr_out}, 32'h1);
        upd1(1'b1);
        upd1(1'b0);
        upd1(1'b1);
        chk("ghr_1101", {28'd0, if1.ghr_out}, 32'hD);
        if1.lookup_valid = 1'b1; if1.lookup_pc = 32'h40;
        tick();
        chk("gs_idx", {26'd0, if1.predict_idx}, 32'h1D);
        chk("gs_p", {31'd0, if1.predict}, 32'd1);
        if1.update_valid = 1'b1; if1.update_idx = 6'd0; if1.update_result = 1'b1;
        tick();
        if1.update_valid = 1'b0;
        chk("gs_old_ghr_idx", {26'd0, if1.predict_idx}, 32'h1D);
        chk("ghr_1011", {28'd0, if1.ghr_out}, 32'hB);
        tick();
        chk("gs_new_ghr_idx", {26'd0, if1.predict_idx}, 32'h1B);
        if1.en = 1'b0;
        if1.update_valid = 1'b1; if1.update_result = 1'b0;
        tick();
        chk("gs_en0_pv", {31'd0, if1.predict_valid}, 32'd0);
        chk("gs_en0_ghr", {28'd0, if1.ghr_out}, 32'hB);
        idle_all();

        // one-bit counters follow the last outcome
        look2("c1_reset", 1'b1);
        upd2(1'b1);
        look2("c1_T", 1'b1);
        upd2(1'b0);
        look2("c1_N", 1'b0);
        upd2(1'b1);
        look2("c1_T2", 1'b1);
        upd2(1'b0);
        upd2(1'b0);
        look2("c1_NN", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
